pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor. Operand is split into 4-bit
//  lookahead groups (full G/P lookahead inside each group); groups are evaluated
//  GROUPS_PER_STAGE per clock, with the inter-stage carry registered.
//  Throughput: one operation per cycle. A valid flag, a global stall, a sub mode and a
//  signed-overflow flag make it usable as the datapath adder of the ALU.
// PARAMETERS
//  WIDTH             16  operand/sum width; multiple of 4, range 4..64
//  GROUPS_PER_STAGE   1  4-bit groups resolved per pipeline stage; must divide WIDTH/4
//  (derived) LATENCY = WIDTH/(4*GROUPS_PER_STAGE) cycles, in_valid -> out_valid
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  stall      in   1      1 = freeze every pipeline register (inputs ignored)
//  in_valid   in   1      a/b/cin/sub are valid this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      0 = a+b+cin ; 1 = a-b (a + ~b + 1, cin ignored)
//  out_valid  out  1      sum/cout/ovf valid this cycle
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry-into-MSB XOR cout
// BEHAVIOUR
//  - Reset: on rising clk with rst=1, every pipeline register clears.
//    out_valid=0, sum=0, cout=0, ovf=0. rst has priority over stall.
//  - Input stage: b_eff = sub ? ~b : b ; c_in = sub ? 1 : cin ; latched with in_valid.
//  - Group logic: g_i=a_i&b_i, p_i=a_i^b_i, c1..c4 from lookahead equations (no ripple
//    inside a group). s_i = p_i ^ c_i.
//  - Stage k (k=0..LATENCY-1) resolves groups k*GPS..(k+1)*GPS-1.
//    * GPS groups inside one stage are chained combinationally via group carries.
//    * Outputs to the next stage: stage carry; sum bits produced so far; the
//      not-yet-used upper operand bits; the valid bit.
//    * Lower sum bits are delayed and upper operand bits skewed through the pipe,
//      so all bits of one operation exit together.
//  - Final stage registers sum, cout, ovf and out_valid. These are outputs directly
//    from flops; no combinational path from inputs to outputs.
//  - Latency: op accepted at edge N (in_valid=1, stall=0) appears at edge N+LATENCY-1.
//    out_valid=1 for exactly one unstalled cycle.
//    * WIDTH=16, GPS=1 -> 4 cycles.
//    * WIDTH=16, GPS=4 -> 1 cycle.
//  - in_valid=0: a bubble propagates. out_valid=0 for it; data values are don't-care
//    but must not disturb neighbouring ops.
//  - stall=1: all registers hold. Outputs stay constant, including out_valid.
//    in_valid in that cycle is ignored and the op is not accepted. No op is lost or
//    duplicated.
//  - Reset mid-operation: all in-flight ops are discarded; none ever reaches out_valid.
//  - Wrap-around: the sum wraps mod 2^WIDTH. cout/ovf report it and there is no
//    saturation.
//  - ovf is meaningful for signed interpretation in both modes. It is always computed
//    and is qualified only by out_valid.
// TESTING  (WIDTH=16, GPS=1 unless noted; latency 4)
//  1 a=16'hABCD b=16'h1234 cin=0 sub=0 -> after 4 cycles:
//    sum=16'hBE01 cout=0 ovf=0.
//  2 a=16'hFFFF b=16'h0001 cin=0 -> sum=16'h0000 cout=1 ovf=0.
//    a=16'h7FFF b=16'h0001 -> sum=16'h8000 cout=0 ovf=1.
//  3 sub=1 a=16'h0005 b=16'h0007 cin=1 -> sum=16'hFFFE cout=0 ovf=0 (cin ignored).
//    sub=1 a=16'h8000 b=16'h0001 -> sum=16'h7FFF cout=1 ovf=1.
//  4 8 back-to-back ops with stall=1 for 2 cycles mid-stream -> 8 results in order.
//    Outputs frozen during the stall; no gaps or duplicates besides the stall.
//  5 3 ops issued, rst=1 for 1 cycle on the next edge -> out_valid stays 0 for the
//    next 6 cycles. A new op after reset returns the correct result at latency 4.
//  6 WIDTH=4 GPS=1 (latency 1):
//    a=4'b1110 b=4'b1001 cin=1 -> sum=4'b1000 cout=1.
//    WIDTH=16 GPS=4 (latency 1) repeats scenario 1 with identical results.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Each register rank resolves GROUPS_PER_STAGE groups; later operand bits are skewed forward.
module pipelined_cla_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW      = 4 * GROUPS_PER_STAGE;
    localparam int LATENCY = WIDTH / SW;

    // Full 4-bit lookahead: every carry is a flat sum of products, no ripple.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    genvar gi, gj;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            localparam int LO  = gi * SW;
            localparam int REM = WIDTH - LO;

            logic [REM-1:0]            a_in;
            logic [REM-1:0]            b_in;
            logic                      c_in;
            logic                      v_in;
            logic [GROUPS_PER_STAGE:0] chain;
            logic [SW-1:0]             s_grp;
            logic [(gi+1)*SW-1:0]      sum_d;
            logic [(gi+1)*SW-1:0]      sum_q;
            logic                      c_q;
            logic                      v_q;

            assign chain[0] = c_in;

            for (gj = 0; gj < GROUPS_PER_STAGE; gj++) begin : g_grp
                logic [4:0] res;
                assign res                = cla4(a_in[gj*4 +: 4], b_in[gj*4 +: 4], chain[gj]);
                assign s_grp[gj*4 +: 4]   = res[3:0];
                assign chain[gj+1]        = res[4];
            end

            if (gi == 0) begin : g_src
                // Subtraction folds into the first stage as a + ~b + 1.
                assign a_in  = a;
                assign b_in  = sub ? ~b : b;
                assign c_in  = sub ? 1'b1 : cin;
                assign v_in  = in_valid;
                assign sum_d = s_grp;
            end else begin : g_src
                assign a_in  = g_stage[gi-1].g_fwd.a_q;
                assign b_in  = g_stage[gi-1].g_fwd.b_q;
                assign c_in  = g_stage[gi-1].c_q;
                assign v_in  = g_stage[gi-1].v_q;
                assign sum_d = {s_grp, g_stage[gi-1].sum_q};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                end else if (!stall) begin
                    v_q   <= v_in;
                    c_q   <= chain[GROUPS_PER_STAGE];
                    sum_q <= sum_d;
                end
            end

            if (gi < LATENCY - 1) begin : g_fwd
                logic [REM-SW-1:0] a_q;
                logic [REM-SW-1:0] b_q;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (!stall) begin
                        a_q <= a_in[REM-1:SW];
                        b_q <= b_in[REM-1:SW];
                    end
                end
            end else begin : g_last
                logic ovf_d;
                logic ovf_q;
                // Carry into the MSB is recovered as p_msb ^ s_msb.
                assign ovf_d = a_in[REM-1] ^ b_in[REM-1] ^ s_grp[SW-1] ^ chain[GROUPS_PER_STAGE];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else if (!stall) begin
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LATENCY-1].v_q;
    assign sum       = g_stage[LATENCY-1].sum_q;
    assign cout      = g_stage[LATENCY-1].c_q;
    assign ovf       = g_stage[LATENCY-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: 16-bit/GPS=1, 4-bit/GPS=1 and 16-bit/GPS=4 instances.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst, stall, in_valid, cin, sub;
    logic [15:0] a, b;
    logic [3:0]  a4, b4;

    logic        ov16, co16, of16;
    logic [15:0] sum16;
    logic        ov4, co4, of4;
    logic [3:0]  sum4;
    logic        ovg, cog, ofg;
    logic [15:0] sumg;

    int checks   = 0;
    int failures = 0;

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov16), .sum(sum16), .cout(co16), .ovf(of16)
    );

    pipelined_cla_adder #(.WIDTH(4), .GROUPS_PER_STAGE(1)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a4), .b(b4),
        .cin(cin), .sub(sub), .out_valid(ov4), .sum(sum4), .cout(co4), .ovf(of4)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(4)) dut_g4 (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ovg), .sum(sumg), .cout(cog), .ovf(ofg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One isolated op on the 16-bit/GPS=1 instance, checked at exactly latency 4.
    task automatic run_op(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo, input logic chk_g4);
        a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (chk_g4) begin
            check_eq({tag, "_g4_valid"}, ovg, 1);
            check_eq({tag, "_g4_sum"}, sumg, es);
            check_eq({tag, "_g4_cout"}, cog, ec);
            check_eq({tag, "_g4_ovf"}, ofg, eo);
        end
        tick();
        tick();
        check_eq({tag, "_early_valid"}, ov16, 0);
        tick();
        check_eq({tag, "_valid"}, ov16, 1);
        check_eq({tag, "_sum"}, sum16, es);
        check_eq({tag, "_cout"}, co16, ec);
        check_eq({tag, "_ovf"}, of16, eo);
        tick();
        check_eq({tag, "_single"}, ov16, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    logic [15:0] opa [8];
    logic [15:0] opb [8];
    logic [16:0] expv [8];
    logic        prev_v;
    logic [16:0] prev_res;
    logic        accept;
    int          issued, recv;

    initial begin
        rst = 1'b1; stall = 1'b1; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a = 16'hABCD; b = 16'h1234; a4 = 4'h0; b4 = 4'h0;
        tick();
        rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
        check_eq("rst_valid", ov16, 0);
        check_eq("rst_res", {of16, co16, sum16}, 0);
        check_eq("rst_valid4", ov4, 0);
        check_eq("rst_validg4", ovg, 0);

        run_op("add_basic", 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b1);
        // Drive the same op again and hit reset together with stall while it is at the output.
        a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        tick();
        check_eq("prio_pre_valid", ov16, 1);
        stall = 1'b1; rst = 1'b1;
        tick();
        stall = 1'b0; rst = 1'b0;
        check_eq("prio_valid", ov16, 0);
        check_eq("prio_sum", sum16, 0);

        run_op("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_cin", 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream with a two-cycle stall while results are emerging.
        for (int i = 0; i < 8; i++) begin
            opa[i]  = 16'h1357 * 16'(i + 1);
            opb[i]  = 16'hA0A1 + 16'h2222 * 16'(i);
            expv[i] = {1'b0, opa[i]} + {1'b0, opb[i]};
        end
        issued = 0; recv = 0; sub = 1'b0; cin = 1'b0;
        prev_v = ov16; prev_res = {co16, sum16};
        for (int c = 0; c < 20; c++) begin
            stall = (c == 5 || c == 6);
            if (stall) begin
                in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
            end else if (issued < 8) begin
                in_valid = 1'b1; a = opa[issued]; b = opb[issued];
            end else begin
                in_valid = 1'b0;
            end
            accept = in_valid && !stall;
            tick();
            if (accept) issued++;
            if (stall) begin
                check_eq("stall_hold_valid", ov16, prev_v);
                check_eq("stall_hold_res", {co16, sum16}, prev_res);
            end else if (ov16) begin
                if (recv < 8) check_eq($sformatf("b2b_res%0d", recv), {co16, sum16}, expv[recv]);
                else check_eq("b2b_extra_valid", ov16, 0);
                recv++;
            end
            prev_v = ov16; prev_res = {co16, sum16};
        end
        stall = 1'b0; in_valid = 1'b0;
        check_eq("b2b_count", recv, 8);

        // Reset with three ops in flight: none of them may surface.
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("flush_valid%0d", k), ov16, 0);
            tick();
        end
        run_op("post_rst", 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0);

        // 4-bit instance, latency 1.
        a4 = 4'b1110; b4 = 4'b1001; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("w4_valid", ov4, 1);
        check_eq("w4_res", {co4, sum4}, 5'b11000);
        check_eq("w4_ovf", of4, 0);
        tick();
        check_eq("w4_single", ov4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
